// File: rtl/ttl_cen_scheduler_if.sv
// Handshake/status bundle between a pause controller and ttl_cen_scheduler.
// Strobe signals exist only when TTL_CEN_STROBE_EN is defined.
interface ttl_cen_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             Pause_req;
    logic             Step;
    logic             Pause_ack;
    logic             Cen;
    logic [CNT_W-1:0] Edge_count;
`ifdef TTL_CEN_STROBE_EN
    logic             Cen_rise;
    logic             Cen_fall;

    modport master (
        output Pause_req, Step,
        input  Pause_ack, Cen, Edge_count, Cen_rise, Cen_fall
    );
    modport slave (
        input  Pause_req, Step,
        output Pause_ack, Cen, Edge_count, Cen_rise, Cen_fall
    );
`else
    modport master (
        output Pause_req, Step,
        input  Pause_ack, Cen, Edge_count
    );
    modport slave (
        input  Pause_req, Step,
        output Pause_ack, Cen, Edge_count
    );
`endif
endinterface

// File: rtl/ttl_cen_scheduler.sv
// Fractional NUM/DEN Cen square-wave generator with pause/ack and single step.
// Optional macro TTL_CEN_STROBE_EN adds registered Cen_rise/Cen_fall pulses.
module ttl_cen_scheduler #(
    parameter int NUM   = 1,
    parameter int DEN   = 2,
    parameter int ACC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    ttl_cen_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             cen_q, cen_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_d;

    logic [ACC_W:0]   sum;
    logic             tick;
    logic [ACC_W-1:0] acc_tick;

    // Phase accumulator: one tick (Cen toggle) per DEN/NUM clocks on average
    always_comb begin
        sum      = {1'b0, acc_q} + (ACC_W+1)'(NUM);
        tick     = (sum >= (ACC_W+1)'(DEN));
        acc_tick = tick ? ACC_W'(sum - (ACC_W+1)'(DEN))
                        : sum[ACC_W-1:0];
    end

    // Next-state logic; pausing only ever lands with Cen low
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cen_d   = cen_q;
        case (state_q)
            RUN: begin
                acc_d = acc_tick;
                cen_d = cen_q ^ tick;
                if (bus.Pause_req)
                    state_d = (!cen_q && !tick) ? PAUSED : DRAIN;
            end
            DRAIN: begin
                acc_d = acc_tick;
                cen_d = cen_q ^ tick;
                if (!bus.Pause_req)
                    state_d = RUN;
                else if (!(cen_q ^ tick))
                    state_d = PAUSED;
            end
            PAUSED: begin
                cen_d = 1'b0;
                if (!bus.Pause_req) begin
                    state_d = RUN;
                end else if (bus.Step) begin
                    state_d = STEP;
                    cen_d   = 1'b1;
                end
            end
            STEP: begin
                cen_d   = 1'b0;
                state_d = bus.Pause_req ? PAUSED : RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        ack_d  = (state_d == PAUSED) || (state_d == STEP);
        rise_d = cen_d & ~cen_q;
        cnt_d  = cnt_q + CNT_W'(rise_d);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RUN;
            acc_q   <= '0;
            cen_q   <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cen_q   <= cen_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Cen        = cen_q;
    assign bus.Pause_ack  = ack_q;
    assign bus.Edge_count = cnt_q;

`ifdef TTL_CEN_STROBE_EN
    logic rise_q;
    logic fall_q;
    logic fall_d;

    // Edge pulses coincident with the Cen transition
    always_comb begin
        fall_d = cen_q & ~cen_d;
    end

    // Strobe registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.Cen_rise = rise_q;
    assign bus.Cen_fall = fall_q;
`endif

endmodule
